// File: rtl/scan_mem_reg_bridge.sv
// scan_mem_reg_bridge: registered bridge from one-at-a-time scan read/write requests
// to SRAM row lanes, NUM_REGS control registers and a read-only status word.
// Optional build macro SCAN_SRAM_RMW_EN: SRAM writes become read-merge-write with
// full-row unmasked writes, for SRAMs without bit masking.
module scan_mem_reg_bridge #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SRAM_W   = 128,
  parameter int unsigned SRAM_AW  = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_ren,
  input  logic                       scan_wen,
  input  logic [ADDR_W-1:0]          scan_addr,
  input  logic [DATA_W-1:0]          scan_wdata,
  output logic [DATA_W-1:0]          scan_rdata,
  output logic                       scan_ready,
  output logic                       scan_err,
  output logic                       scan_busy,
  output logic                       sram_ren,
  output logic                       sram_wen,
  output logic [SRAM_AW-1:0]         sram_addr,
  output logic [SRAM_W-1:0]          sram_bweb,
  output logic [SRAM_W-1:0]          sram_wdata,
  input  logic [SRAM_W-1:0]          sram_rdata,
  input  logic                       sram_ready,
  output logic [NUM_REGS-1:0]        reg_ren,
  output logic [NUM_REGS-1:0]        reg_wen,
  output logic [DATA_W-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  input  logic [NUM_REGS-1:0]        reg_ready,
  input  logic [DATA_W-1:0]          stat_in
);

  localparam int unsigned LANES     = SRAM_W / DATA_W;
  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned LB        = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int unsigned IDX_BITS  = $clog2(NUM_REGS + 1);
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  req_wr, req_wr_d;
  logic                  req_reg, req_reg_d;
  logic [IDX_BITS-1:0]   req_idx, req_idx_d;
  logic [LB-1:0]         req_lane, req_lane_d;
  logic [SRAM_AW-1:0]    req_row, req_row_d;
  logic [DATA_W-1:0]     req_wdata, req_wdata_d;

  logic [DATA_W-1:0]     rdata_d;
  logic                  ready_d, err_d, busy_d;
  logic                  sram_ren_d, sram_wen_d;
  logic [SRAM_AW-1:0]    sram_addr_d;
  logic [SRAM_W-1:0]     sram_bweb_d, sram_wdata_d;
  logic [NUM_REGS-1:0]   reg_ren_d, reg_wen_d;
  logic [DATA_W-1:0]     reg_wdata_d;

  logic                  hit;
  logic [DATA_W-1:0]     tgt_rdata;
  logic [LB-1:0]         lane_in;
  logic [IDX_BITS-1:0]   idx_in;

`ifdef SCAN_SRAM_RMW_EN
  logic                  rmw_wr, rmw_wr_d;
  logic [SRAM_W-1:0]     row_buf, row_buf_d;
  logic [SRAM_W-1:0]     merged;
`endif

  // State, captured request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_wr     <= 1'b0;
      req_reg    <= 1'b0;
      req_idx    <= '0;
      req_lane   <= '0;
      req_row    <= '0;
      req_wdata  <= '0;
      scan_rdata <= '0;
      scan_ready <= 1'b0;
      scan_err   <= 1'b0;
      scan_busy  <= 1'b0;
      sram_ren   <= 1'b0;
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_bweb  <= '0;
      sram_wdata <= '0;
      reg_ren    <= '0;
      reg_wen    <= '0;
      reg_wdata  <= '0;
`ifdef SCAN_SRAM_RMW_EN
      rmw_wr     <= 1'b0;
      row_buf    <= '0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      req_wr     <= req_wr_d;
      req_reg    <= req_reg_d;
      req_idx    <= req_idx_d;
      req_lane   <= req_lane_d;
      req_row    <= req_row_d;
      req_wdata  <= req_wdata_d;
      scan_rdata <= rdata_d;
      scan_ready <= ready_d;
      scan_err   <= err_d;
      scan_busy  <= busy_d;
      sram_ren   <= sram_ren_d;
      sram_wen   <= sram_wen_d;
      sram_addr  <= sram_addr_d;
      sram_bweb  <= sram_bweb_d;
      sram_wdata <= sram_wdata_d;
      reg_ren    <= reg_ren_d;
      reg_wen    <= reg_wen_d;
      reg_wdata  <= reg_wdata_d;
`ifdef SCAN_SRAM_RMW_EN
      rmw_wr     <= rmw_wr_d;
      row_buf    <= row_buf_d;
`endif
    end
  end

  // Next state, captured request and next output values
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    req_wr_d     = req_wr;
    req_reg_d    = req_reg;
    req_idx_d    = req_idx;
    req_lane_d   = req_lane;
    req_row_d    = req_row;
    req_wdata_d  = req_wdata;
    rdata_d      = scan_rdata;
    ready_d      = 1'b0;
    err_d        = scan_err;
    busy_d       = scan_busy;
    sram_ren_d   = 1'b0;
    sram_wen_d   = 1'b0;
    sram_addr_d  = sram_addr;
    sram_bweb_d  = sram_bweb;
    sram_wdata_d = sram_wdata;
    reg_ren_d    = '0;
    reg_wen_d    = '0;
    reg_wdata_d  = reg_wdata;
    hit          = 1'b0;
    tgt_rdata    = '0;
    lane_in      = (LANE_BITS > 0) ? LB'(scan_addr[LB-1:0]) : '0;
    idx_in       = scan_addr[IDX_BITS-1:0];
`ifdef SCAN_SRAM_RMW_EN
    rmw_wr_d     = rmw_wr;
    row_buf_d    = row_buf;
    merged       = sram_rdata;
    for (int l = 0; l < LANES; l++) begin
      if (req_lane == LB'(l)) merged[l*DATA_W +: DATA_W] = req_wdata;
    end
`endif

    // Only the selected target's ready and data are observed
    if (req_reg) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (req_idx == IDX_BITS'(i)) begin
          hit       = reg_ready[i];
          tgt_rdata = reg_rdata[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      hit = sram_ready;
      for (int l = 0; l < LANES; l++) begin
        if (req_lane == LB'(l)) tgt_rdata = sram_rdata[l*DATA_W +: DATA_W];
      end
    end

    case (state)
      S_IDLE: begin
        if (scan_ren || scan_wen) begin
          busy_d      = 1'b1;
          req_wr_d    = scan_wen;
          req_reg_d   = scan_addr[ADDR_W-1];
          req_idx_d   = idx_in;
          req_lane_d  = lane_in;
          req_row_d   = scan_addr[LANE_BITS +: SRAM_AW];
          req_wdata_d = scan_wdata;
`ifdef SCAN_SRAM_RMW_EN
          rmw_wr_d    = 1'b0;
`endif
          if (scan_ren && scan_wen) begin
            state_d = S_RESP; ready_d = 1'b1; err_d = 1'b1; rdata_d = ERR_DATA;
          end else if (scan_addr[ADDR_W-1] && idx_in == IDX_BITS'(NUM_REGS)) begin
            state_d = S_RESP; ready_d = 1'b1;
            err_d   = scan_wen;
            rdata_d = scan_wen ? ERR_DATA : stat_in;
          end else if (scan_addr[ADDR_W-1] && idx_in > IDX_BITS'(NUM_REGS)) begin
            state_d = S_RESP; ready_d = 1'b1; err_d = 1'b1; rdata_d = ERR_DATA;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit) begin
`ifdef SCAN_SRAM_RMW_EN
          if (!req_reg && req_wr && !rmw_wr) begin
            row_buf_d = merged;
            rmw_wr_d  = 1'b1;
            state_d   = S_ACCESS;
          end else
`endif
          begin
            state_d = S_RESP; ready_d = 1'b1; err_d = 1'b0;
            rdata_d = req_wr ? '0 : tgt_rdata;
          end
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          state_d = S_RESP; ready_d = 1'b1; err_d = 1'b1; rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Target strobes and payload are launched on entry to ACCESS
    if (state_d == S_ACCESS) begin
      if (req_reg_d) begin
        reg_ren_d   = req_wr_d ? '0 : (NUM_REGS'(1) << req_idx_d);
        reg_wen_d   = req_wr_d ? (NUM_REGS'(1) << req_idx_d) : '0;
        reg_wdata_d = req_wdata_d;
      end else begin
        sram_addr_d = req_row_d;
`ifdef SCAN_SRAM_RMW_EN
        if (req_wr_d && rmw_wr_d) begin
          sram_wen_d   = 1'b1;
          sram_wdata_d = row_buf_d;
          sram_bweb_d  = '0;
        end else begin
          sram_ren_d = 1'b1;
        end
`else
        if (req_wr_d) begin
          sram_wen_d   = 1'b1;
          sram_wdata_d = '0;
          sram_bweb_d  = '1;
          for (int l = 0; l < LANES; l++) begin
            if (req_lane_d == LB'(l)) begin
              sram_wdata_d[l*DATA_W +: DATA_W] = req_wdata_d;
              sram_bweb_d[l*DATA_W +: DATA_W]  = '0;
            end
          end
        end else begin
          sram_ren_d = 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_scan_mem_reg_bridge.sv
// Directed self-checking bench for scan_mem_reg_bridge (default parameters).
module tb_scan_mem_reg_bridge;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_ren, scan_wen;
  logic [10:0]   scan_addr;
  logic [31:0]   scan_wdata, scan_rdata;
  logic          scan_ready, scan_err, scan_busy;
  logic          sram_ren, sram_wen;
  logic [7:0]    sram_addr;
  logic [127:0]  sram_bweb, sram_wdata, sram_rdata;
  logic          sram_ready;
  logic [3:0]    reg_ren, reg_wen;
  logic [31:0]   reg_wdata;
  logic [127:0]  reg_rdata;
  logic [3:0]    reg_ready;
  logic [31:0]   stat_in;

  int checks = 0;
  int errors = 0;

  scan_mem_reg_bridge dut (
    .clk(clk), .rst(rst),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr),
    .scan_wdata(scan_wdata), .scan_rdata(scan_rdata), .scan_ready(scan_ready),
    .scan_err(scan_err), .scan_busy(scan_busy),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_bweb(sram_bweb), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready),
    .reg_ren(reg_ren), .reg_wen(reg_wen), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready), .stat_in(stat_in)
  );

  always #5 clk = ~clk;

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; scan_ren = 0; scan_wen = 0; scan_addr = '0; scan_wdata = '0;
    sram_rdata = '0; sram_ready = 0; reg_rdata = '0; reg_ready = '0; stat_in = '0;
    step(); step();
    chk("rst_ready", 128'(scan_ready), 128'h0);
    chk("rst_busy",  128'(scan_busy),  128'h0);
    chk("rst_rdata", 128'(scan_rdata), 128'h0);
    chk("rst_bweb",  sram_bweb,        128'h0);
    chk("rst_strb",  128'({sram_ren, sram_wen, reg_ren, reg_wen}), 128'h0);
    rst = 1'b0;
    step();

    // SRAM write lane 2 of row 1, ready two cycles after the strobe
    scan_wen = 1; scan_addr = 11'h006; scan_wdata = 32'hA5A5A5A5;
    step(); scan_wen = 0;
`ifndef SCAN_SRAM_RMW_EN
    chk("wr_wen",   128'(sram_wen),  128'h1);
    chk("wr_ren",   128'(sram_ren),  128'h0);
    chk("wr_addr",  128'(sram_addr), 128'h1);
    chk("wr_bweb",  sram_bweb,  {32'hFFFFFFFF, 32'h0, 64'hFFFFFFFF_FFFFFFFF});
    chk("wr_wdata", sram_wdata, {32'h0, 32'hA5A5A5A5, 64'h0});
    chk("wr_busy",  128'(scan_busy), 128'h1);
    step();
    chk("wr_wen_pulse", 128'(sram_wen), 128'h0);
    step(); sram_ready = 1;
    chk("wr_ready_early", 128'(scan_ready), 128'h0);
    step(); sram_ready = 0;
    chk("wr_ready", 128'(scan_ready), 128'h1);
    chk("wr_err",   128'(scan_err),   128'h0);
    chk("wr_rdata", 128'(scan_rdata), 128'h0);
    step();
    chk("wr_ready_pulse", 128'(scan_ready), 128'h0);
    chk("wr_busy_fall",   128'(scan_busy),  128'h0);

    // SRAM read lane 3 of row 1, earliest ready
    scan_ren = 1; scan_addr = 11'h007;
    sram_rdata = {32'h12345678, 32'h11111111, 32'h22222222, 32'h33333333};
    step(); scan_ren = 0;
    chk("rd_ren",   128'(sram_ren),  128'h1);
    chk("rd_addr",  128'(sram_addr), 128'h1);
    chk("rd_wdata_hold", sram_wdata, {32'h0, 32'hA5A5A5A5, 64'h0});
    step(); sram_ready = 1;
    step(); sram_ready = 0;
    chk("rd_ready", 128'(scan_ready), 128'h1);
    chk("rd_rdata", 128'(scan_rdata), 128'h12345678);
    chk("rd_err",   128'(scan_err),   128'h0);
    step();
`endif

    // Register write idx 2, a foreign ready is ignored
    scan_wen = 1; scan_addr = 11'h402; scan_wdata = 32'h7;
    step(); scan_wen = 0;
    chk("rw_wen",   128'(reg_wen),   128'h4);
    chk("rw_ren",   128'(reg_ren),   128'h0);
    chk("rw_wdata", 128'(reg_wdata), 128'h7);
    step(); reg_ready = 4'b0001;
    chk("rw_wen_pulse", 128'(reg_wen), 128'h0);
    step(); reg_ready = 4'b0100;
    chk("rw_foreign_ignored", 128'(scan_ready), 128'h0);
    step(); reg_ready = '0;
    chk("rw_ready", 128'(scan_ready), 128'h1);
    chk("rw_err",   128'(scan_err),   128'h0);
    chk("rw_rdata", 128'(scan_rdata), 128'h0);
    step();

    // Status read, sampled at accept
    scan_ren = 1; scan_addr = 11'h404; stat_in = 32'h1;
    step(); scan_ren = 0; stat_in = 32'h2;
    chk("st_ready", 128'(scan_ready), 128'h1);
    chk("st_rdata", 128'(scan_rdata), 128'h1);
    chk("st_err",   128'(scan_err),   128'h0);
    step();

    // Status write is an error
    scan_wen = 1; scan_addr = 11'h404;
    step(); scan_wen = 0;
    chk("stw_err",   128'(scan_err),   128'h1);
    chk("stw_rdata", 128'(scan_rdata), 128'hDEADBEEF);
    step();

    // Register read idx 1 timing out, with busy-time requests and foreign readies
    scan_ren = 1; scan_addr = 11'h401; reg_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
    step(); scan_ren = 0;
    chk("to_ren", 128'(reg_ren), 128'h2);
    for (int c = 2; c <= 17; c++) begin
      step();
      if (c == 4) begin scan_wen = 1; scan_addr = 11'h006; reg_ready = 4'b1101; end
      if (c == 10) begin scan_wen = 0; reg_ready = '0; end
      chk($sformatf("to_wait_c%0d", c), 128'({scan_ready, sram_wen, reg_wen}), 128'h0);
    end
    step();
    chk("to_ready", 128'(scan_ready), 128'h1);
    chk("to_err",   128'(scan_err),   128'h1);
    chk("to_rdata", 128'(scan_rdata), 128'hDEADBEEF);
    step();
    chk("to_busy_fall", 128'(scan_busy), 128'h0);
    step();
    chk("to_not_queued", 128'({scan_busy, sram_wen, sram_ren}), 128'h0);

    // Simultaneous read and write
    scan_ren = 1; scan_wen = 1; scan_addr = 11'h006;
    step(); scan_ren = 0; scan_wen = 0;
    chk("both_err",   128'({scan_ready, scan_err}), 128'h3);
    chk("both_rdata", 128'(scan_rdata), 128'hDEADBEEF);
    chk("both_strb",  128'({sram_ren, sram_wen, reg_ren, reg_wen}), 128'h0);
    step();

    // Index beyond the status word
    scan_ren = 1; scan_addr = 11'h405;
    step(); scan_ren = 0;
    chk("oor_err",  128'({scan_ready, scan_err}), 128'h3);
    chk("oor_strb", 128'({reg_ren, reg_wen}), 128'h0);
    step();

    // Reset while waiting, then a late ready
    scan_ren = 1; scan_addr = 11'h003;
    step(); scan_ren = 0;
    chk("rs_ren", 128'(sram_ren), 128'h1);
    step(); rst = 1;
    step(); rst = 0; sram_ready = 1;
    chk("rs_busy", 128'(scan_busy), 128'h0);
    step(); sram_ready = 0;
    chk("rs_no_ready", 128'(scan_ready), 128'h0);
    step();
    chk("rs_no_ready2", 128'({scan_ready, scan_busy}), 128'h0);

    // Lane 0 write of an all-ones row with zero data
    scan_wen = 1; scan_addr = 11'h010; scan_wdata = 32'h0;
    step(); scan_wen = 0;
`ifdef SCAN_SRAM_RMW_EN
    chk("rmw_rd_strb", 128'({sram_ren, sram_wen}), 128'h2);
    chk("rmw_addr",    128'(sram_addr), 128'h4);
    step(); sram_rdata = '1; sram_ready = 1;
    step(); sram_ready = 0;
    chk("rmw_wr_strb", 128'({sram_ren, sram_wen}), 128'h1);
    chk("rmw_wdata",   sram_wdata, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0});
    chk("rmw_bweb",    sram_bweb, 128'h0);
    step(); sram_ready = 1;
    step(); sram_ready = 0;
    chk("rmw_resp", 128'({scan_ready, scan_err}), 128'h2);
`else
    chk("l0_wen",   128'(sram_wen),  128'h1);
    chk("l0_addr",  128'(sram_addr), 128'h4);
    chk("l0_bweb",  sram_bweb,  {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0});
    chk("l0_wdata", sram_wdata, 128'h0);
    step(); sram_ready = 1;
    step(); sram_ready = 0;
    chk("l0_resp", 128'({scan_ready, scan_err}), 128'h2);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_mem_reg_bridge.md
Name: scan_mem_reg_bridge

Overview:
Parametrised, registered successor to the combinational scan mem/reg mux. Accepts one scan read/write at a time and decodes it to a wide SRAM row lane or to one of NUM_REGS control registers or the status word. Drives single-cycle target strobes, waits for the target's ready with a timeout, and returns one registered response with an error flag. Sits between scan_syn_ctr and the SRAM/FFT control registers.

Parameters:
ADDR_W, 11, scan address width; MSB selects region (0 = SRAM, 1 = registers)
DATA_W, 32, scan data width
SRAM_W, 128, SRAM row width; LANES = SRAM_W/DATA_W, power of 2, >= 1
SRAM_AW, 8, SRAM row address width; LANE_BITS + SRAM_AW <= ADDR_W-1
NUM_REGS, 4, number of control registers; status word sits at index NUM_REGS
TIMEOUT, 15, cycles to wait for target ready before erroring, >= 1
ERR_DATA, 32'hDEADBEEF, scan_rdata value on any error response

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
scan_ren  in  1  read request, sampled in IDLE
scan_wen  in  1  write request, sampled in IDLE
scan_addr  in  ADDR_W  request address
scan_wdata  in  DATA_W  write data
scan_rdata  out  DATA_W  read data, valid with scan_ready
scan_ready  out  1  one-cycle response pulse
scan_err  out  1  error flag, valid with scan_ready
scan_busy  out  1  high from accept until the cycle after scan_ready
sram_ren  out  1  SRAM read strobe
sram_wen  out  1  SRAM write strobe
sram_addr  out  SRAM_AW  SRAM row
sram_bweb  out  SRAM_W  bit write enable, active-low (0 = write bit)
sram_wdata  out  SRAM_W  SRAM write data
sram_rdata  in  SRAM_W  SRAM read data, valid with sram_ready
sram_ready  in  1  SRAM completion
reg_ren  out  NUM_REGS  one-hot register read strobes
reg_wen  out  NUM_REGS  one-hot register write strobes
reg_wdata  out  DATA_W  shared register write data
reg_rdata  in  NUM_REGS*DATA_W  register read data, reg i at [i*DATA_W +: DATA_W]
reg_ready  in  NUM_REGS  per-register completion
stat_in  in  DATA_W  status word (e.g. fft_done in bit 0)

Behaviour:
- Reset: all outputs 0, FSM to IDLE, timeout counter 0, captured request cleared.
- Decode: lane = addr[LANE_BITS-1:0]; row = addr[LANE_BITS +: SRAM_AW]; reg idx = addr[IDX_BITS-1:0], where IDX_BITS = $clog2(NUM_REGS+1); higher reg-region bits are ignored.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if exactly one of scan_ren/scan_wen is high, capture addr/wdata/op and set scan_busy. Then:
  - reg idx == NUM_REGS, read: go to RESP with rdata = stat_in sampled at accept.
  - reg idx == NUM_REGS, write: RESP, err = 1.
  - reg idx > NUM_REGS: RESP, err = 1.
  - otherwise: go to ACCESS.
- IDLE, both ren and wen high: accepted, RESP, err = 1, no target strobe.
- ACCESS (1 cycle): assert exactly one strobe for 1 cycle. For SRAM, sram_addr = row; write places wdata in the lane, other bits 0; bweb = 0 on the lane, 1 elsewhere. For registers, reg_ren[idx] or reg_wen[idx], reg_wdata = wdata. Clear the counter and go to WAIT.
- WAIT: watch only the selected target's ready (sram_ready, or reg_ready[idx]); other readies are ignored. On ready:
  - read: capture lane slice, or reg_rdata slice, into scan_rdata.
  - go to RESP, err = 0.
  - else count up; when the counter reaches TIMEOUT, go to RESP with err = 1.
- RESP: scan_ready = 1 for exactly 1 cycle.
  - err = 1: scan_rdata = ERR_DATA.
  - write response: scan_rdata = 0.
  - Return to IDLE; scan_busy falls on the following cycle.
- Requests while busy: ignored, not queued.
- Latency: accept at cycle 0, strobe at cycle 1, earliest target ready at cycle 2, scan_ready at cycle 3. Status reads and decode errors: scan_ready at cycle 1.
- sram_addr, sram_wdata, sram_bweb and reg_wdata hold their values from ACCESS until the next ACCESS.
- Reset mid-operation: state is lost, no response is issued, and a late target ready in IDLE is ignored.

Optional Feature:
SCAN_SRAM_RMW_EN:
- Defined: for SRAMs without bit masking.
  - SRAM write becomes read (ACCESS/WAIT), then merge scan_wdata into the lane of the captured row, then a second ACCESS/WAIT write with the full row and sram_bweb all 0.
  - The timeout applies to each phase independently.
  - An error in the read phase aborts with no write.
- Undefined: single masked write as above.

Test Plan:
- SRAM write, addr 0x006, wdata 0xA5A5A5A5, ready 2 cycles after strobe -> sram_addr=1, bweb[95:64]=0, others 1, wdata[95:64]=0xA5A5A5A5; scan_ready one cycle, err=0.
- SRAM read, addr 0x007, sram_rdata[127:96]=0x12345678 -> scan_rdata=0x12345678 at cycle 3.
- Register write idx 2 (addr 0x402), wdata 0x7 -> reg_wen=4'b0100 for 1 cycle, reg_wdata=7; then read idx 4 with stat_in=1 -> scan_rdata=1 at cycle 1.
- Register read idx 1, reg_ready never asserted, TIMEOUT=15 -> scan_ready 17 cycles after the strobe, err=1, rdata=0xDEADBEEF; busy-time requests ignored.
- scan_ren & scan_wen together; addr 0x405 with NUM_REGS=4 -> err=1, no strobes; rst pulse in WAIT, then sram_ready -> no scan_ready.
- With SCAN_SRAM_RMW_EN, write lane 0 of a row holding 0xFFFF...FF with 0 -> read strobe, then write strobe with wdata 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000 and bweb all 0.
